// File: rtl/instructions_pkg.sv
// Shared RV32 subset decode types, instruction formats and
// multicycle controller state encoding.
package instructions_pkg;

  typedef enum logic [2:0] {
    INST_R, INST_I, INST_S, INST_B,
    INST_U, INST_J, INST_X
  } inst_type_e;

  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;
  localparam logic [6:0] OPC_S = 7'h23;
  localparam logic [6:0] OPC_B = 7'h63;
  localparam logic [6:0] OPC_U = 7'h17;
  localparam logic [6:0] OPC_J = 7'h6F;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_fmt_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_fmt_t;

  typedef struct packed {
    logic [6:0] imm2;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm1;
    logic [6:0] opcode;
  } s_fmt_t;

  typedef struct packed {
    logic       imm4;
    logic [5:0] imm3;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm2;
    logic       imm1;
    logic [6:0] opcode;
  } b_fmt_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_fmt_t;

  typedef struct packed {
    logic       imm4;
    logic [9:0] imm3;
    logic       imm2;
    logic [7:0] imm1;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_fmt_t;

  typedef union packed {
    r_fmt_t r;
    i_fmt_t i;
    s_fmt_t s;
    b_fmt_t b;
    u_fmt_t u;
    j_fmt_t j;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, FWAIT, DECODE,
    EXEC, MEM, WB, TRAP
  } ctrl_state_e;

  function automatic inst_type_e decode_type(
    input logic [6:0] opc
  );
    inst_type_e t;
    case (opc)
      OPC_R:   t = INST_R;
      OPC_I:   t = INST_I;
      OPC_S:   t = INST_S;
      OPC_B:   t = INST_B;
      OPC_U:   t = INST_U;
      OPC_J:   t = INST_J;
      default: t = INST_X;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction fetch and data store handshake bundle
// between the multicycle controller and memory.
interface rv_multicycle_ctrl_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o,
    input  imem_gnt_i, imem_rvalid_i,
    input  imem_rdata_i, dmem_gnt_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o,
    output imem_gnt_i, imem_rvalid_i,
    output imem_rdata_i, dmem_gnt_i
  );
endinterface

// File: rtl/rv_multicycle_ctrl_imm_gen.sv
// rv_imm_gen: immediate extraction and ALU operand-B
// select for the decoded instruction format.
module rv_imm_gen
  import instructions_pkg::*;
(
  input  instruction_t inst,
  output logic [31:0]  imm,
  output logic         alu_src_imm
);

  inst_type_e t;

  assign t = decode_type(inst.r.opcode);

  always_comb begin
    imm         = '0;
    alu_src_imm = 1'b0;
    unique case (1'b1)
      t == INST_I: begin
        imm = {{20{inst.i.imm[11]}}, inst.i.imm};
        alu_src_imm = 1'b1;
      end
      t == INST_S: begin
        imm = {{20{inst.s.imm2[6]}},
               inst.s.imm2, inst.s.imm1};
        alu_src_imm = 1'b1;
      end
      t == INST_B: begin
        imm = {{19{inst.b.imm4}}, inst.b.imm4,
               inst.b.imm1, inst.b.imm3,
               inst.b.imm2, 1'b0};
      end
      t == INST_U: begin
        imm = {inst.u.imm, 12'b0};
        alu_src_imm = 1'b1;
      end
      t == INST_J: begin
        imm = {{11{inst.j.imm4}}, inst.j.imm4,
               inst.j.imm1, inst.j.imm2,
               inst.j.imm3, 1'b0};
        alu_src_imm = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32-subset control FSM owning PC and IR.
// RV_CTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP.
module rv_multicycle_ctrl
  import instructions_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        halt_i,
  rv_multicycle_ctrl_if.master        bus,
  input  logic                        br_taken_i,
  output logic [31:0]                 pc_o,
  output logic [31:0]                 ir_o,
  output logic [31:0]                 imm_o,
  output logic                        alu_src_imm_o,
  output logic                        rf_we_o,
  output logic                        busy_o,
  output logic                        illegal_o
);

  ctrl_state_e  state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  instruction_t ir_q, ir_d;
  logic         ill_q, ill_d;
  logic         entry_q;
  logic [31:0]  imm;
  logic         src_imm;
  inst_type_e   itype;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_tgt;

  rv_imm_gen u_imm_gen (
    .inst        (ir_q),
    .imm         (imm),
    .alu_src_imm (src_imm)
  );

  assign itype    = decode_type(ir_q.r.opcode);
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_tgt   = (pc_q + imm) & 32'hFFFF_FFFC;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    ill_d           = ill_q;
    bus.imem_req_o  = 1'b0;
    bus.dmem_req_o  = 1'b0;
    rf_we_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        // halt only counts on the first FETCH cycle
        if (entry_q && halt_i) begin
          state_d = IDLE;
        end else begin
          bus.imem_req_o = 1'b1;
          if (bus.imem_gnt_i) state_d = FWAIT;
        end
      end
      FWAIT: begin
        if (bus.imem_rvalid_i) begin
          ir_d    = bus.imem_rdata_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (itype == INST_X) begin
          ill_d = 1'b1;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          pc_d    = pc_plus4;
          state_d = FETCH;
`endif
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          itype == INST_S: state_d = MEM;
          itype == INST_B: begin
            pc_d    = br_taken_i ? pc_tgt : pc_plus4;
            state_d = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        bus.dmem_req_o = 1'b1;
        if (bus.dmem_gnt_i) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      WB: begin
        rf_we_o = (ir_q.r.rd != 5'd0);
        pc_d    = (itype == INST_J) ? pc_tgt : pc_plus4;
        state_d = FETCH;
      end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      ill_q   <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
      entry_q <= (state_d == FETCH) && (state_q != FETCH);
    end
  end

  assign bus.imem_addr_o = pc_q;
  assign pc_o            = pc_q;
  assign ir_o            = ir_q;
  assign busy_o          = (state_q != IDLE);
  assign illegal_o       = ill_q;
  assign imm_o           = busy_o ? imm : '0;
  assign alu_src_imm_o   = busy_o ? src_imm : 1'b0;

endmodule
